// File: rtl/charge_scatter.sv
// rtl/charge_scatter.sv - particle-to-grid cloud-in-cell charge deposition engine
// Optional CHARGE_SAT_EN: saturating accumulation with sticky sat_flag output.
module charge_scatter #(
  parameter int NUM_PART = 16384,
  parameter int WSHIFT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic [49:0] p_data,
  output logic        rd_en,
  output logic [11:0] rd_addr,
  input  logic [35:0] rd_data,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [35:0] wr_data,
  output logic        busy,
`ifdef CHARGE_SAT_EN
  output logic        sat_flag,
`endif
  output logic        done
);

  localparam int CNTW = $clog2(NUM_PART + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nx;
  logic              held;
  logic [1:0]        corner;
  logic [5:0]        hx_i, hy_i;
  logic [11:0]       hx_f, hy_f;
  logic [CNTW-1:0]   count;
  logic              accept;
  logic              pipe_empty;

  logic [12:0]       wx, wy;
  logic [24:0]       w;
  logic [35:0]       contrib_a;
  logic [11:0]       a_addr;

  logic              b_vld;
  logic [11:0]       b_addr;
  logic [35:0]       b_contrib;
  logic [35:0]       operand;
  logic [35:0]       sum_b;

  logic              h_vld;
  logic [11:0]       h_addr;
  logic [35:0]       h_data;

  logic              unused_vperp;
  assign unused_vperp = ^p_data[13:0];

  assign p_ready    = (state == RUN) && (count < CNTW'(NUM_PART)) && (!held || corner == 2'd3);
  assign accept     = p_valid && p_ready;
  assign pipe_empty = !held && !b_vld && !wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (count == CNTW'(NUM_PART)) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Held particle walks its four corners; a new particle may land on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held   <= 1'b0;
      corner <= 2'd0;
      hx_i   <= '0;
      hx_f   <= '0;
      hy_i   <= '0;
      hy_f   <= '0;
      count  <= '0;
    end else begin
      if (state == IDLE && start) count <= '0;
      if (accept) begin
        held   <= 1'b1;
        corner <= 2'd0;
        hy_i   <= p_data[49:44];
        hy_f   <= p_data[43:32];
        hx_i   <= p_data[31:26];
        hx_f   <= p_data[25:14];
        count  <= count + 1'b1;
      end else if (held) begin
        corner <= corner + 2'd1;
        if (corner == 2'd3) held <= 1'b0;
      end
    end
  end

  assign wx        = corner[0] ? {1'b0, hx_f} : 13'd4096 - {1'b0, hx_f};
  assign wy        = corner[1] ? {1'b0, hy_f} : 13'd4096 - {1'b0, hy_f};
  assign w         = {12'd0, wy} * {12'd0, wx};
  assign contrib_a = {11'd0, w >> WSHIFT};
  assign a_addr    = {hy_i + {5'd0, corner[1]}, hx_i + {5'd0, corner[0]}};

  assign rd_en     = held;
  assign rd_addr   = a_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld     <= 1'b0;
      b_addr    <= '0;
      b_contrib <= '0;
    end else begin
      b_vld     <= held;
      b_addr    <= a_addr;
      b_contrib <= contrib_a;
    end
  end

  // RAM is read-first, so the two most recent writes are not yet visible in rd_data.
  always_comb begin
    if (wr_en && wr_addr == b_addr)      operand = wr_data;
    else if (h_vld && h_addr == b_addr)  operand = h_data;
    else                                 operand = rd_data;
  end

`ifdef CHARGE_SAT_EN
  logic [36:0] sum_wide;
  logic        sat_hit;
  assign sum_wide = {1'b0, operand} + {1'b0, b_contrib};
  assign sat_hit  = b_vld && sum_wide[36];
  assign sum_b    = sum_wide[36] ? 36'hF_FFFF_FFFF : sum_wide[35:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     sat_flag <= 1'b0;
    else if (state == IDLE && start) sat_flag <= 1'b0;
    else if (sat_hit)               sat_flag <= 1'b1;
  end
`else
  assign sum_b = operand + b_contrib;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      h_vld   <= 1'b0;
      h_addr  <= '0;
      h_data  <= '0;
    end else begin
      wr_en <= b_vld;
      if (b_vld) begin
        wr_addr <= b_addr;
        wr_data <= sum_b;
      end
      h_vld <= wr_en;
      if (wr_en) begin
        h_addr <= wr_addr;
        h_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_charge_scatter.sv
// tb/tb_charge_scatter.sv - self-checking bench for charge_scatter with grid RAM and reference model
module tb_charge_scatter;
  localparam int NP = 4;
  localparam int WS = 0;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, p_valid = 1'b0;
  logic [49:0] p_data = '0;
  logic        p_ready, rd_en, wr_en, busy, done;
  logic [11:0] rd_addr, wr_addr;
  logic [35:0] rd_data, wr_data;
`ifdef CHARGE_SAT_EN
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  charge_scatter #(.NUM_PART(NP), .WSHIFT(WS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p_valid(p_valid), .p_ready(p_ready),
    .p_data(p_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
`ifdef CHARGE_SAT_EN
    .sat_flag(sat_flag),
`endif
    .done(done)
  );

  // Read-first grid RAM with one-cycle read latency
  logic [35:0] mem [4096];
  logic        clr = 1'b0, ld = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [35:0] ld_val = '0;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      if (ld) mem[ld_addr] <= ld_val;
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  typedef struct { logic [11:0] addr; logic [35:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [35:0] exp_mem [4096];
  logic [11:0] obs_addr [16];
  logic [35:0] obs_data [16];

  int checks = 0, errors = 0;
  int cyc = 0, wr_seen = 0, done_cnt = 0, done_cyc = 0, last_wr = 0, first_wr = -1;
  int acc_cyc = 0, frame_w0 = 0, frame_d0 = 0, ready_bad = 0, sent = 0;
  bit drain_watch = 0;

  function automatic logic [17:0] pos(input int ip, input int fr);
    return {6'(ip), 12'(fr)};
  endfunction

  function automatic logic [11:0] ga(input int y, input int x);
    return {6'(y), 6'(x)};
  endfunction

  task automatic tick;
    int idx;
    @(negedge clk);
    cyc++;
    if (wr_en) begin
      idx = wr_seen - frame_w0;
      if (idx >= 0 && idx < 16) begin
        obs_addr[idx] = wr_addr;
        obs_data[idx] = wr_data;
      end
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr %h data %h, no write expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          errors++;
          $display("FAIL write_stream got %h:%h want %h:%h", wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (drain_watch && p_ready) ready_bad++;
  endtask

  task automatic clear_mem;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = '0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [35:0] v);
    ld = 1'b1; ld_addr = a; ld_val = v;
    tick;
    ld = 1'b0;
    exp_mem[a] = v;
  endtask

  // Reference: bilinear weights straight from the fractions, accumulated in an array
  task automatic model_accept(input logic [17:0] py, input logic [17:0] px);
    for (int k = 0; k < 4; k++) begin
      int dx = k % 2;
      int dy = k / 2;
      int fx = int'(px[11:0]);
      int fy = int'(py[11:0]);
      int wxv = (dx == 1) ? fx : 4096 - fx;
      int wyv = (dy == 1) ? fy : 4096 - fy;
      longint contrib = longint'(wxv) * longint'(wyv);
      logic [11:0] a;
      logic [36:0] s;
      contrib = contrib >>> WS;
      a = {6'(int'(py[17:12]) + dy), 6'(int'(px[17:12]) + dx)};
      s = {1'b0, exp_mem[a]} + 37'(contrib);
`ifdef CHARGE_SAT_EN
      if (s[36]) s = 37'h0F_FFFF_FFFF;
`endif
      exp_mem[a] = s[35:0];
      exp_q.push_back('{a, s[35:0]});
    end
  endtask

  task automatic send(input logic [17:0] py, input logic [17:0] px, input int gap);
    int n;
    p_valid = 1'b0;
    repeat (gap) tick;
    p_valid = 1'b1;
    p_data  = {py, px, 14'($urandom)};
    n = 0;
    while (!p_ready && n < 64) begin
      tick;
      n++;
    end
    if (!p_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout p_ready stayed %b after %0d cycles, want 1", p_ready, n);
    end else begin
      model_accept(py, px);
      acc_cyc = cyc;
      sent++;
    end
    tick;
    p_valid = 1'b0;
    if (sent == NP) drain_watch = 1;
  endtask

  task automatic begin_frame;
    frame_w0 = wr_seen;
    frame_d0 = done_cnt;
    first_wr = -1;
    ready_bad = 0;
    drain_watch = 0;
    sent = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic end_frame;
    int n = 0;
    while (done_cnt == frame_d0 && n < 200) begin
      tick;
      n++;
    end
    repeat (4) tick;
    drain_watch = 0;
    checks++;
    if (done_cnt - frame_d0 != 1) begin
      errors++; $display("FAIL done_count got %0d want 1", done_cnt - frame_d0);
    end
    checks++;
    if (wr_seen - frame_w0 != 4 * NP) begin
      errors++; $display("FAIL write_count got %0d want %0d", wr_seen - frame_w0, 4 * NP);
    end
    checks++;
    if (done_cyc != last_wr + 1) begin
      errors++; $display("FAIL done_timing done at %0d want %0d", done_cyc, last_wr + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (ready_bad != 0) begin
      errors++; $display("FAIL ready_after_last got %0d cycles high want 0", ready_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_frame got %b want 0", busy);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({p_ready, rd_en, wr_en, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {p_ready, rd_en, wr_en, busy, done});
    end
    checks++;
    if (rd_addr !== 12'h0 || wr_addr !== 12'h0 || wr_data !== 36'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0 0 0", rd_addr, wr_addr, wr_data);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_zero_frac;
    int acc0;
    clear_mem;
    begin_frame;
    send(pos(7, 0), pos(5, 0), 0);
    acc0 = acc_cyc;
    for (int i = 0; i < 3; i++) send(pos(40, 0), pos(40, 0), 0);
    end_frame;
    checks++;
    if (first_wr - acc0 != 3) begin
      errors++; $display("FAIL first_write_latency got %0d want 3", first_wr - acc0);
    end
    checks++;
    if (mem[ga(7, 5)] !== 36'h001000000 || mem[ga(7, 6)] !== 36'h0 ||
        mem[ga(8, 5)] !== 36'h0 || mem[ga(8, 6)] !== 36'h0) begin
      errors++;
      $display("FAIL zero_frac_corners got %h %h %h %h want 001000000 0 0 0",
               mem[ga(7, 5)], mem[ga(7, 6)], mem[ga(8, 5)], mem[ga(8, 6)]);
    end
  endtask

  task automatic corner_frame(input int y, input int x, input logic [11:0] e0, input logic [11:0] e1,
                              input logic [11:0] e2, input logic [11:0] e3);
    logic [11:0] ea [4];
    ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e3;
    clear_mem;
    begin_frame;
    send(pos(y, 12'h800), pos(x, 12'h800), 0);
    for (int i = 0; i < 3; i++) send(pos(40, 0), pos(40, 0), 0);
    end_frame;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_addr[k] !== ea[k] || obs_data[k] !== 36'h000400000) begin
        errors++;
        $display("FAIL half_corner%0d got %h:%h want %h:000400000", k, obs_addr[k], obs_data[k], ea[k]);
      end
    end
  endtask

  task automatic test_half_frac;
    corner_frame(20, 10, ga(20, 10), ga(20, 11), ga(21, 10), ga(21, 11));
  endtask

  task automatic test_wrap;
    corner_frame(63, 63, ga(63, 63), ga(63, 0), ga(0, 63), ga(0, 0));
  endtask

  task automatic test_back_to_back;
    clear_mem;
    begin_frame;
    send(pos(3, 12'h800), pos(3, 12'h800), 0);
    send(pos(4, 0), pos(4, 0), 0);
    send(pos(4, 0), pos(5, 0), 0);
    send(pos(40, 0), pos(40, 0), 0);
    end_frame;
    checks++;
    if (mem[ga(4, 4)] !== 36'h001400000) begin
      errors++; $display("FAIL b2b_cell44 got %h want 001400000", mem[ga(4, 4)]);
    end
    checks++;
    if (obs_data[4] !== 36'h001400000) begin
      errors++; $display("FAIL b2b_forward got %h want 001400000", obs_data[4]);
    end
    checks++;
    if (mem[ga(4, 5)] !== 36'h001000000) begin
      errors++; $display("FAIL b2b_cell45 got %h want 001000000", mem[ga(4, 5)]);
    end
  endtask

  task automatic test_random_frame;
    int bad;
    for (int f = 0; f < 3; f++) begin
      begin_frame;
      for (int i = 0; i < NP; i++) begin
        int yi = (f == 2) ? 62 + $urandom_range(0, 3) : $urandom_range(0, 2);
        int xi = (f == 2) ? 62 + $urandom_range(0, 3) : $urandom_range(0, 2);
        int yf = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4095);
        int xf = $urandom_range(0, 4095);
        if (i == 2) begin
          start = 1'b1;
          tick;
          start = 1'b0;
        end
        send(pos(yi, yf), pos(xi, xf), (f == 0) ? 0 : $urandom_range(0, 3));
      end
      end_frame;
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_ram_image got %0d bad cells want 0", bad);
    end
  endtask

  task automatic test_saturation;
    clear_mem;
    preload(ga(0, 0), 36'hFFFFFFF00);
    begin_frame;
    send(pos(0, 0), pos(0, 0), 0);
    for (int i = 0; i < 3; i++) send(pos(40, 0), pos(40, 0), 1);
    end_frame;
    checks++;
`ifdef CHARGE_SAT_EN
    if (obs_data[0] !== 36'hFFFFFFFFF || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_result got %h flag %b want fffffffff flag 1", obs_data[0], sat_flag);
    end
`else
    if (obs_data[0] !== 36'h000FFFF00) begin
      errors++; $display("FAIL wrap_result got %h want 000ffff00", obs_data[0]);
    end
`endif
  endtask

  task automatic test_reset_midframe;
    int w0, d0;
    clear_mem;
    begin_frame;
    send(pos(10, 12'h123), pos(11, 12'h456), 0);
    send(pos(12, 0), pos(13, 0), 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, rd_en, busy, p_ready} !== 4'b0) begin
      errors++; $display("FAIL abort_strobes got %b want 0000", {wr_en, rd_en, busy, p_ready});
    end
    exp_q.delete();
    drain_watch = 0;
    w0 = wr_seen;
    d0 = done_cnt;
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (12) tick;
    checks++;
    if (wr_seen != w0 || done_cnt != d0) begin
      errors++; $display("FAIL abort_quiet got %0d writes %0d dones want 0 0", wr_seen - w0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset;
    test_zero_frac;
    test_half_frac;
    test_wrap;
    test_back_to_back;
    test_random_frame;
    test_saturation;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
